// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
// Used by cla_seq_adder; the CLA_SEQ_OVF_EN build option lives in the top.
package cla_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } cla_seq_st_e;

  function automatic int unsigned nib_cnt(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla.sv
// Existing 4-bit carry-lookahead adder; purely combinational.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that runs one nibble per clock through a single shared 4-bit CLA.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = nib_cnt(WIDTH);
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  cla_seq_st_e      state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [3:0] cla_sum;
  logic       cla_cout;
  logic       last_step;

  cla cla_inst (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  assign last_step = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // New nibble enters at the top so the first one lands at bit 0 after N steps.
        sum_sh_d = {cla_sum, sum_sh_q[WIDTH-1:4]};
        a_sh_d   = {4'b0, a_sh_q[WIDTH-1:4]};
        b_sh_d   = {4'b0, b_sh_q[WIDTH-1:4]};
        carry_d  = cla_cout;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow is MSB carry-out XOR MSB carry-in; the carry-in is recovered from the sum bit.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StRun && last_step) begin
      ovf_d = cla_cout ^ (cla_sum[3] ^ a_sh_q[3] ^ b_sh_q[3]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder at WIDTH=16 and WIDTH=8.
// Overflow scenarios run only when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        out_valid8;
  logic [7:0]  sum8;
  logic        cout8;

`ifdef CLA_SEQ_OVF_EN
  logic ovf;
  logic ovf8;
`endif

  int n_cmp;
  int n_fail;

  cla_seq_adder #(.WIDTH(16)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  cla_seq_adder #(.WIDTH(8)) dut8 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .sum       (sum8),
    .cout      (cout8)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation for one edge; returns just after the acceptance edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); n_fail++; end
    n_cmp++; if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++; end
    n_cmp++; if (sum !== 16'h0000) begin
      $display("FAIL reset_sum: got %h expected 0000", sum); n_fail++; end
    n_cmp++; if (cout !== 1'b0) begin
      $display("FAIL reset_cout: got %b expected 0", cout); n_fail++; end
`ifdef CLA_SEQ_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin
      $display("FAIL reset_ovf: got %b expected 0", ovf); n_fail++; end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc;
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc !== 4) begin
      $display("FAIL basic_latency: got %0d expected 4", cyc); n_fail++; end
    n_cmp++; if (sum !== 16'h0003) begin
      $display("FAIL basic_sum: got %h expected 0003", sum); n_fail++; end
    n_cmp++; if (cout !== 1'b0) begin
      $display("FAIL basic_cout: got %b expected 0", cout); n_fail++; end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL basic_back_idle: got in_ready=%b out_valid=%b expected 1/0",
               in_ready, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_carry_chain();
    int cyc;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    // Operands changed after acceptance must not affect the result.
    a = 16'h1234; b = 16'h4321; cin = 1'b1;
    wait_done(cyc);
    n_cmp++; if (cyc !== 4) begin
      $display("FAIL carry_latency: got %0d expected 4", cyc); n_fail++; end
    n_cmp++; if (sum !== 16'h0000) begin
      $display("FAIL carry_sum: got %h expected 0000", sum); n_fail++; end
    n_cmp++; if (cout !== 1'b1) begin
      $display("FAIL carry_cout: got %b expected 1", cout); n_fail++; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mixed();
    int cyc;
    start_op(16'hA5C3, 16'h6E7D, 1'b1);
    wait_done(cyc);
    // 0xA5C3 + 0x6E7D + 1 = 0x11441
    n_cmp++; if (sum !== 16'h1441 || cout !== 1'b1) begin
      $display("FAIL mixed_result: got %b_%h expected 1_1441", cout, sum); n_fail++; end
    @(posedge clk);
    #1;
  endtask

`ifdef CLA_SEQ_OVF_EN
  task automatic test_ovf();
    int cyc;
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++; if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b expected 8000/0/1", sum, cout, ovf);
      n_fail++;
    end
    @(posedge clk);
    #1;
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done(cyc);
    n_cmp++; if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1) begin
      $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b expected 0000/1/1", sum, cout, ovf);
      n_fail++;
    end
    @(posedge clk);
    #1;
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_done(cyc);
    n_cmp++; if (ovf !== 1'b0) begin
      $display("FAIL ovf_none: got %b expected 0", ovf); n_fail++; end
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_done(cyc);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL bp_hs_%0d: got out_valid=%b in_ready=%b expected 1/0",
                 i, out_valid, in_ready);
        n_fail++;
      end
      n_cmp++; if (sum !== 16'h3333 || cout !== 1'b0) begin
        $display("FAIL bp_hold_%0d: got %b_%h expected 0_3333", i, cout, sum); n_fail++; end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0",
               in_ready, out_valid);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(cyc);
    n_cmp++; if (cyc !== 4) begin
      $display("FAIL bp_next_latency: got %0d expected 4", cyc); n_fail++; end
    n_cmp++; if (sum !== 16'h1010 || cout !== 1'b0) begin
      $display("FAIL bp_next_sum: got %b_%h expected 0_1010", cout, sum); n_fail++; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    int cyc;
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midrst_hs: got out_valid=%b in_ready=%b expected 0/1",
               out_valid, in_ready);
      n_fail++;
    end
    n_cmp++; if (sum !== 16'h0000 || cout !== 1'b0) begin
      $display("FAIL midrst_out: got %b_%h expected 0_0000", cout, sum); n_fail++; end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) cyc++;
    end
    n_cmp++; if (cyc !== 0) begin
      $display("FAIL midrst_no_result: got %0d valid cycles expected 0", cyc); n_fail++; end
    start_op(16'h0005, 16'h0003, 1'b1);
    wait_done(cyc);
    n_cmp++; if (cyc !== 4) begin
      $display("FAIL midrst_next_latency: got %0d expected 4", cyc); n_fail++; end
    n_cmp++; if (sum !== 16'h0009 || cout !== 1'b0) begin
      $display("FAIL midrst_next_sum: got %b_%h expected 0_0009", cout, sum); n_fail++; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_width8();
    int cyc;
    a8 = 8'h98; b8 = 8'h01; cin8 = 1'b1;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++; if (cyc !== 2) begin
      $display("FAIL w8_latency: got %0d expected 2", cyc); n_fail++; end
    n_cmp++; if (sum8 !== 8'h9A || cout8 !== 1'b0) begin
      $display("FAIL w8_sum: got %b_%h expected 0_9a", cout8, sum8); n_fail++; end
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready8 !== 1'b1) begin
      $display("FAIL w8_back_idle: got %b expected 1", in_ready8); n_fail++; end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_mixed();
`ifdef CLA_SEQ_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_reset_midop();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
